ov5640_sccb_writer: RTL

SCCB (I2C-like) 3-phase write master for OV5640 sensor register programming. Sits directly downstream of the HPS register/FIFO stage. Consumes the (start, 16-bit address, 8-bit data) command stream and issues a ready handshake that gates the FIFO read. Drives the sensor SIOC/SIOD open-drain pins and reports ACK errors.

---
 rtl/ov5640_sccb_writer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ov5640_sccb_writer.sv
// SCCB (I2C-like) 3-phase write master for OV5640 register programming.
// One (address, data) command is pulled per ready offer. SIOC/SIOD are driven from registered outputs.
module ov5640_sccb_writer #(
  parameter int         CLK_FREQ_HZ  = 50000000,
  parameter int         SCCB_FREQ_HZ = 100000,
  parameter logic [7:0] DEV_ADDR     = 8'h78,
  parameter int         QDIV         = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ)
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] address,
  input  logic [7:0]  data,
  output logic        ready,
  output logic        sioc,
  output logic        siod_oe,
  input  logic        siod_in,
  output logic        busy,
  output logic        done,
  output logic        ack_err
);

  localparam int             QW    = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [QW-1:0]  QLAST = QW'(QDIV - 1);

  typedef enum logic [2:0] {IDLE, OFFER, WAIT, START_C, SHIFT, STOP_C, GAP} state_t;

  state_t        state, state_next;
  logic [QW-1:0] qcnt_reg;
  logic [1:0]    quarter_reg;
  logic [5:0]    bit_reg;
  logic [3:0]    pos_reg;
  logic          win_reg;
  logic [31:0]   shift_reg;
  logic          err_reg;
  logic          sioc_reg, oe_reg, ready_reg, busy_reg, done_reg, ack_err_reg;

  logic q_tick, bit_end, ack_slot, ack_sample;
  logic sioc_next, oe_next, done_next;

  assign q_tick     = (qcnt_reg == QLAST);
  assign bit_end    = q_tick && (quarter_reg == 2'd3);
  assign ack_slot   = (pos_reg == 4'd8);
  assign ack_sample = (state == SHIFT) && ack_slot && (quarter_reg == 2'd2) && (qcnt_reg == '0);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    sioc_next  = 1'b1;
    oe_next    = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE:  state_next = OFFER;
      OFFER: state_next = WAIT;
      WAIT: begin
        if (start)        state_next = START_C;
        else if (win_reg) state_next = IDLE;
      end
      START_C: begin
        sioc_next = (quarter_reg != 2'd3);
        oe_next   = (quarter_reg != 2'd0);
        if (bit_end) state_next = SHIFT;
      end
      SHIFT: begin
        // SIOD only moves on a bit boundary, which always falls in the SIOC-low half
        sioc_next = quarter_reg[1];
        oe_next   = ack_slot ? 1'b0 : ~shift_reg[31];
        if (bit_end && (bit_reg == 6'd35)) state_next = STOP_C;
      end
      STOP_C: begin
        sioc_next = (quarter_reg != 2'd0);
        oe_next   = (quarter_reg < 2'd2);
        done_next = bit_end;
        if (bit_end) state_next = GAP;
      end
      GAP: begin
        if (bit_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      qcnt_reg    <= '0;
      quarter_reg <= 2'd0;
      bit_reg     <= 6'd0;
      pos_reg     <= 4'd0;
      win_reg     <= 1'b0;
      shift_reg   <= 32'd0;
      err_reg     <= 1'b0;
      sioc_reg    <= 1'b1;
      oe_reg      <= 1'b0;
      ready_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      ack_err_reg <= 1'b0;
    end else begin
      sioc_reg    <= sioc_next;
      oe_reg      <= oe_next;
      ready_reg   <= (state == OFFER);
      busy_reg    <= (state_next == START_C) || (state_next == SHIFT) ||
                     (state_next == STOP_C)  || (state_next == GAP);
      done_reg    <= done_next;
      ack_err_reg <= done_next && err_reg;
      win_reg     <= (state == WAIT) ? ~win_reg : 1'b0;

      if (state != state_next) begin
        qcnt_reg    <= '0;
        quarter_reg <= 2'd0;
      end else if (q_tick) begin
        qcnt_reg    <= '0;
        quarter_reg <= quarter_reg + 2'd1;
      end else begin
        qcnt_reg    <= qcnt_reg + 1'b1;
      end

      if ((state == WAIT) && start) begin
        shift_reg <= {DEV_ADDR, address, data};
        err_reg   <= 1'b0;
        bit_reg   <= 6'd0;
        pos_reg   <= 4'd0;
      end else if ((state == SHIFT) && bit_end) begin
        if (bit_reg != 6'd35) bit_reg <= bit_reg + 6'd1;
        if (ack_slot) begin
          pos_reg <= 4'd0;
        end else begin
          pos_reg   <= pos_reg + 4'd1;
          shift_reg <= {shift_reg[30:0], 1'b0};
        end
      end

      if (ack_sample && siod_in) err_reg <= 1'b1;
    end
  end

  assign sioc    = sioc_reg;
  assign siod_oe = oe_reg;
  assign ready   = ready_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign ack_err = ack_err_reg;

  // Upstream only ever answers an offer, so a strobe anywhere else is a handshake bug.
  a_start_in_window: assert property (@(posedge clk_sys) disable iff (!reset_n) start |-> (state == WAIT));

endmodule
